// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC datapath: fetch (T0-T2),
// then opcode-specific execute steps (T3-T7), then back to fetch.
module control_unit #(
  parameter int OP_HI = 31,
  parameter int OP_W  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  output logic        run,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        IncPC,
  output logic        Read,
  output logic        read_mem,
  output logic        write_mem,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op;
  logic            is_ld, is_st, is_ldi, is_alu, is_imm, is_halt;
  logic            unused_ir;

  // Decode straight from the live IR port every cycle.
  assign op        = IR[OP_HI -: OP_W];
  assign unused_ir = ^IR;
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_ldi    = (op == OP_LDI);
  assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm    = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  assign is_halt   = (op == OP_HALT);
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_halt)                                     state_d = S_HALT;
        else if (is_ld || is_st || is_ldi || is_alu || is_imm) state_d = S_T4;
        else                                             state_d = S_T0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (is_ld || is_st) ? S_T6 : S_T0;
      S_T6:   state_d = S_T7;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    run = 1'b0; PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0; Cout = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; read_mem = 1'b0; write_mem = 1'b0;
    ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
    unique case (state_q)
      S_T0: begin
        run = 1'b1; IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1; Read = 1'b1; read_mem = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Read = 1'b1; read_mem = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_ld || is_st || is_ldi) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_ld || is_st || is_ldi) begin
          Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
        end else if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          ADD = (op == OP_ADD); SUB = (op == OP_SUB);
          AND = (op == OP_AND); OR  = (op == OP_OR);
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1;
          ADD = (op == OP_ADDI); AND = (op == OP_ANDI); OR = (op == OP_ORI);
        end
      end
      S_T5: begin
        run = 1'b1;
        if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_ldi || is_alu || is_imm) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (is_ld) begin
          Read = 1'b1; read_mem = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          write_mem = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle comparison of the whole control word
// against a per-instruction step table built from the opcode's meaning.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] ir;
  logic        run, PCout, MDRout, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read, read_mem, write_mem;
  logic        ADD, SUB, AND, OR;
  logic [3:0]  state_o;
  logic [24:0] obs;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam int R_RUN = 24, R_PCOUT = 23, R_MDROUT = 22, R_ZLOW = 21, R_COUT = 20;
  localparam int R_GRA = 19, R_GRB = 18, R_GRC = 17, R_RIN = 16, R_ROUT = 15;
  localparam int R_BAOUT = 14, R_PCIN = 13, R_IRIN = 12, R_MARIN = 11, R_MDRIN = 10;
  localparam int R_YIN = 9, R_ZIN = 8, R_INCPC = 7, R_READ = 6, R_RMEM = 5;
  localparam int R_WMEM = 4, R_ADD = 3, R_SUB = 2, R_AND = 1, R_OR = 0;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI = 5'b01110, OP_NOP = 5'b11010, OP_HALT = 5'b11011;

  logic [24:0] exp_q[$];

  control_unit #(.OP_HI(31), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .IR(ir), .run(run),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .IncPC(IncPC), .Read(Read), .read_mem(read_mem), .write_mem(write_mem),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .state_o(state_o)
  );

  assign obs = {run, PCout, MDRout, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout,
                PCin, IRin, MARin, MDRin, Yin, Zin, IncPC, Read, read_mem, write_mem,
                ADD, SUB, AND, OR};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] b(input int i);
    return 25'(1) << i;
  endfunction

  // Reference model: the full sequence of control words one instruction produces.
  function automatic void push_instr(input logic [4:0] op);
    logic [24:0] run_b;
    int          sel;
    string       cls;
    run_b = b(R_RUN);
    sel   = R_ADD;
    case (op)
      OP_LD:   cls = "ld";
      OP_ST:   cls = "st";
      OP_LDI:  cls = "ldi";
      OP_ADD:  begin cls = "alu"; sel = R_ADD; end
      OP_SUB:  begin cls = "alu"; sel = R_SUB; end
      OP_AND:  begin cls = "alu"; sel = R_AND; end
      OP_OR:   begin cls = "alu"; sel = R_OR;  end
      OP_ADDI: begin cls = "imm"; sel = R_ADD; end
      OP_ANDI: begin cls = "imm"; sel = R_AND; end
      OP_ORI:  begin cls = "imm"; sel = R_OR;  end
      OP_HALT: cls = "halt";
      default: cls = "nop";
    endcase
    exp_q.push_back(run_b | b(R_INCPC) | b(R_PCIN) | b(R_MARIN) | b(R_READ) | b(R_RMEM));
    exp_q.push_back(run_b | b(R_READ) | b(R_RMEM) | b(R_MDRIN));
    exp_q.push_back(run_b | b(R_MDROUT) | b(R_IRIN));
    if (cls == "ld" || cls == "st" || cls == "ldi") begin
      exp_q.push_back(run_b | b(R_GRB) | b(R_BAOUT) | b(R_YIN));
      exp_q.push_back(run_b | b(R_COUT) | b(R_ADD) | b(R_ZIN));
      if (cls == "ldi") begin
        exp_q.push_back(run_b | b(R_ZLOW) | b(R_GRA) | b(R_RIN));
      end else begin
        exp_q.push_back(run_b | b(R_ZLOW) | b(R_MARIN));
        if (cls == "ld") begin
          exp_q.push_back(run_b | b(R_READ) | b(R_RMEM) | b(R_MDRIN));
          exp_q.push_back(run_b | b(R_MDROUT) | b(R_GRA) | b(R_RIN));
        end else begin
          exp_q.push_back(run_b | b(R_GRA) | b(R_ROUT) | b(R_MDRIN));
          exp_q.push_back(run_b | b(R_WMEM));
        end
      end
    end else if (cls == "alu" || cls == "imm") begin
      exp_q.push_back(run_b | b(R_GRB) | b(R_ROUT) | b(R_YIN));
      if (cls == "alu") exp_q.push_back(run_b | b(R_GRC) | b(R_ROUT) | b(sel) | b(R_ZIN));
      else              exp_q.push_back(run_b | b(R_COUT) | b(sel) | b(R_ZIN));
      exp_q.push_back(run_b | b(R_ZLOW) | b(R_GRA) | b(R_RIN));
    end else if (cls == "halt") begin
      exp_q.push_back(run_b);
      for (int i = 0; i < 20; i++) exp_q.push_back(25'd0);
    end else begin
      exp_q.push_back(run_b);
    end
  endfunction

  // Scoreboard comparison
  task automatic check(input logic [24:0] e, input string tag);
    chk_cnt++;
    assert (obs === e) pass_cnt++;
    else $error("FAIL %s: observed=%h expected=%h state=%0d", tag, obs, e, state_o);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  // Driver: run one instruction, optionally pulsing reset during step abort_at.
  task automatic run_instr(input logic [31:0] ir_val, input int abort_at);
    logic [24:0] e;
    push_instr(ir_val[31:27]);
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == 0) ir = ir_val;
      e = exp_q.pop_front();
      check(e, $sformatf("op%b_step%0d", ir_val[31:27], i));
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1 check(25'd0, "async_reset_mid_instr");
        exp_q.delete();
        @(negedge clk);
        check(25'd0, "held_reset");
        reset = 1'b1;
      end
    end
  endtask

  initial begin
    logic [4:0] r;
    reset = 1'b0;
    ir    = 32'd0;
    repeat (2) begin
      @(negedge clk);
      check(25'd0, "in_reset");
    end
    reset = 1'b1;
    #1 check(25'd0, "reset_released");

    run_instr(32'h0A080005, -1);
    run_instr(mk(OP_LD), -1);
    run_instr(mk(OP_ST), -1);
    run_instr(mk(OP_SUB), -1);
    run_instr(mk(OP_ANDI), -1);
    run_instr(mk(OP_NOP), -1);

    repeat (40) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 9))
          0: r = OP_LD;   1: r = OP_LDI;  2: r = OP_ST;   3: r = OP_ADD;
          4: r = OP_SUB;  5: r = OP_AND;  6: r = OP_OR;   7: r = OP_ADDI;
          8: r = OP_ANDI; default: r = OP_ORI;
        endcase
      end else begin
        r = 5'($urandom_range(0, 31));
        if (r == OP_HALT) r = OP_NOP;
      end
      run_instr(mk(r), -1);
    end

    run_instr(mk(5'b10101), -1);
    run_instr(mk(OP_LD), 6);
    run_instr(mk(OP_LDI), -1);

    run_instr(mk(OP_HALT), -1);
    @(negedge clk);
    reset = 1'b0;
    #1 check(25'd0, "halt_reset_pulse");
    @(negedge clk);
    check(25'd0, "halt_reset_held");
    reset = 1'b1;
    run_instr(mk(OP_ADD), -1);
    run_instr(mk(OP_ORI), -1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
